// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
//   Single-outstanding APB master. Accepts one command on a valid/ready
//   handshake, runs the APB SETUP/ACCESS sequence and returns a one-cycle
//   response pulse. The ACCESS phase can be aborted after TIMEOUT_CYCLES
//   wait states (0 disables the abort). All APB and response outputs are
//   registered.
//
// Ports
//   PCLK, PRESETn        clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_write/addr/      command fields, latched at acceptance
//   wdata/strb
//   rsp_valid            one-cycle completion pulse (no backpressure)
//   rsp_rdata/err/       response fields, held between pulses
//   timeout
//   PSEL..PSTRB          APB request outputs
//   PRDATA/PREADY/       APB slave response inputs, used only in ACCESS
//   PSLVERR
// ---------------------------------------------------------------------------
module apb_master #(
   parameter int ADDR_W         = 8,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                PCLK,
   input  logic                PRESETn,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_strb,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                rsp_timeout,
   output logic                PSEL,
   output logic                PENABLE,
   output logic                PWRITE,
   output logic [ADDR_W-1:0]   PADDR,
   output logic [DATA_W-1:0]   PWDATA,
   output logic [DATA_W/8-1:0] PSTRB,
   input  logic [DATA_W-1:0]   PRDATA,
   input  logic                PREADY,
   input  logic                PSLVERR
);

   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS
   } state_t;

   state_t              r_state,       w_state_nxt;
   logic                r_cmd_ready,   w_cmd_ready_nxt;
   logic                r_rsp_valid,   w_rsp_valid_nxt;
   logic [DATA_W-1:0]   r_rsp_rdata,   w_rsp_rdata_nxt;
   logic                r_rsp_err,     w_rsp_err_nxt;
   logic                r_rsp_timeout, w_rsp_timeout_nxt;
   logic                r_psel,        w_psel_nxt;
   logic                r_penable,     w_penable_nxt;
   logic                r_pwrite,      w_pwrite_nxt;
   logic [ADDR_W-1:0]   r_paddr,       w_paddr_nxt;
   logic [DATA_W-1:0]   r_pwdata,      w_pwdata_nxt;
   logic [STRB_W-1:0]   r_pstrb,       w_pstrb_nxt;
   logic [CNT_W-1:0]    r_cnt,         w_cnt_nxt;
   logic [CNT_W-1:0]    w_cnt_inc;

   assign w_cnt_inc = r_cnt + CNT_W'(1);

   always_comb begin
      w_state_nxt       = r_state;
      w_rsp_valid_nxt   = 1'b0;
      w_rsp_rdata_nxt   = r_rsp_rdata;
      w_rsp_err_nxt     = r_rsp_err;
      w_rsp_timeout_nxt = r_rsp_timeout;
      w_psel_nxt        = r_psel;
      w_penable_nxt     = r_penable;
      w_pwrite_nxt      = r_pwrite;
      w_paddr_nxt       = r_paddr;
      w_pwdata_nxt      = r_pwdata;
      w_pstrb_nxt       = r_pstrb;
      w_cnt_nxt         = r_cnt;

      case (r_state)
         S_IDLE: begin
            // The APB request registers double as the command latch.
            if (cmd_valid && r_cmd_ready) begin
               w_state_nxt   = S_SETUP;
               w_psel_nxt    = 1'b1;
               w_penable_nxt = 1'b0;
               w_pwrite_nxt  = cmd_write;
               w_paddr_nxt   = cmd_addr;
               w_pwdata_nxt  = cmd_write ? cmd_wdata : '0;
               w_pstrb_nxt   = cmd_write ? cmd_strb  : '0;
            end
         end
         S_SETUP: begin
            w_state_nxt   = S_ACCESS;
            w_penable_nxt = 1'b1;
            w_cnt_nxt     = '0;
         end
         S_ACCESS: begin
            // PREADY wins over the timeout on the limit cycle.
            if (PREADY) begin
               w_state_nxt       = S_IDLE;
               w_psel_nxt        = 1'b0;
               w_penable_nxt     = 1'b0;
               w_rsp_valid_nxt   = 1'b1;
               w_rsp_err_nxt     = PSLVERR;
               w_rsp_timeout_nxt = 1'b0;
               w_rsp_rdata_nxt   = r_pwrite ? '0 : PRDATA;
            end else if ((TIMEOUT_CYCLES != 0) && (w_cnt_inc == TO_LIMIT)) begin
               w_state_nxt       = S_IDLE;
               w_psel_nxt        = 1'b0;
               w_penable_nxt     = 1'b0;
               w_rsp_valid_nxt   = 1'b1;
               w_rsp_err_nxt     = 1'b1;
               w_rsp_timeout_nxt = 1'b1;
               w_rsp_rdata_nxt   = '0;
               w_cnt_nxt         = w_cnt_inc;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         default: begin
            w_state_nxt   = S_IDLE;
            w_psel_nxt    = 1'b0;
            w_penable_nxt = 1'b0;
         end
      endcase

      // Ready is registered, so it rises in the same cycle as rsp_valid.
      w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state       <= S_IDLE;
         r_cmd_ready   <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
         r_psel        <= 1'b0;
         r_penable     <= 1'b0;
         r_pwrite      <= 1'b0;
         r_paddr       <= '0;
         r_pwdata      <= '0;
         r_pstrb       <= '0;
         r_cnt         <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_cmd_ready   <= w_cmd_ready_nxt;
         r_rsp_valid   <= w_rsp_valid_nxt;
         r_rsp_rdata   <= w_rsp_rdata_nxt;
         r_rsp_err     <= w_rsp_err_nxt;
         r_rsp_timeout <= w_rsp_timeout_nxt;
         r_psel        <= w_psel_nxt;
         r_penable     <= w_penable_nxt;
         r_pwrite      <= w_pwrite_nxt;
         r_paddr       <= w_paddr_nxt;
         r_pwdata      <= w_pwdata_nxt;
         r_pstrb       <= w_pstrb_nxt;
         r_cnt         <= w_cnt_nxt;
      end
   end

   assign cmd_ready   = r_cmd_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_err     = r_rsp_err;
   assign rsp_timeout = r_rsp_timeout;
   assign PSEL        = r_psel;
   assign PENABLE     = r_penable;
   assign PWRITE      = r_pwrite;
   assign PADDR       = r_paddr;
   assign PWDATA      = r_pwdata;
   assign PSTRB       = r_pstrb;

endmodule

// File: tb/tb_apb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_master
//   Directed bench for apb_master. One instance uses a 16-cycle timeout, a
//   second instance has the timeout disabled. Inputs change 1 time unit
//   after the rising edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_apb_master;

   logic        PCLK = 1'b0;
   logic        PRESETn = 1'b1;

   logic        cmd_valid = 1'b0, cmd_write = 1'b0;
   logic [7:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_strb = '0;
   logic [31:0] PRDATA = '0;
   logic        PREADY = 1'b0, PSLVERR = 1'b0;
   logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata, PWDATA;
   logic        PSEL, PENABLE, PWRITE;
   logic [7:0]  PADDR;
   logic [3:0]  PSTRB;

   logic        z_cmd_valid = 1'b0, z_cmd_write = 1'b0;
   logic [7:0]  z_cmd_addr = '0;
   logic [31:0] z_cmd_wdata = '0;
   logic [3:0]  z_cmd_strb = '0;
   logic [31:0] z_PRDATA = '0;
   logic        z_PREADY = 1'b0, z_PSLVERR = 1'b0;
   logic        z_cmd_ready, z_rsp_valid, z_rsp_err, z_rsp_timeout;
   logic [31:0] z_rsp_rdata, z_PWDATA;
   logic        z_PSEL, z_PENABLE, z_PWRITE;
   logic [7:0]  z_PADDR;
   logic [3:0]  z_PSTRB;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   int unsigned bad;

   always #5 PCLK = ~PCLK;

   apb_master #(.ADDR_W(8), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .rsp_timeout(rsp_timeout),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PSTRB(PSTRB),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   apb_master #(.ADDR_W(8), .DATA_W(32), .TIMEOUT_CYCLES(0)) dut0 (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .cmd_valid(z_cmd_valid), .cmd_ready(z_cmd_ready), .cmd_write(z_cmd_write),
      .cmd_addr(z_cmd_addr), .cmd_wdata(z_cmd_wdata), .cmd_strb(z_cmd_strb),
      .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err),
      .rsp_timeout(z_rsp_timeout),
      .PSEL(z_PSEL), .PENABLE(z_PENABLE), .PWRITE(z_PWRITE), .PADDR(z_PADDR),
      .PWDATA(z_PWDATA), .PSTRB(z_PSTRB),
      .PRDATA(z_PRDATA), .PREADY(z_PREADY), .PSLVERR(z_PSLVERR)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   initial begin
      // ---------------- reset ----------------
      #1 PRESETn = 1'b0;
      #1;
      chk("rst_apb",  {PSEL, PENABLE, PWRITE, PADDR, PSTRB}, 0);
      chk("rst_pwd",  PWDATA, 0);
      chk("rst_rsp",  {cmd_ready, rsp_valid, rsp_err, rsp_timeout}, 0);
      chk("rst_rdat", rsp_rdata, 0);
      tick;
      tick;
      PRESETn = 1'b1;
      chk("rdy_before_edge", cmd_ready, 0);
      tick;
      chk("rdy_after_edge", cmd_ready, 1);
      chk("idle_psel", {PSEL, PENABLE}, 2'b00);

      // ---------------- write, zero wait ----------------
      cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h10;
      cmd_wdata = 32'hDEADBEEF; cmd_strb = 4'hF;
      PREADY = 1; PRDATA = 32'hAAAA5555;
      tick;
      chk("w1_setup", {PSEL, PENABLE, PWRITE, cmd_ready}, 4'b1010);
      chk("w1_paddr", PADDR, 8'h10);
      chk("w1_pwdata", PWDATA, 32'hDEADBEEF);
      chk("w1_pstrb", PSTRB, 4'hF);
      cmd_valid = 0; cmd_addr = 8'hFF; cmd_wdata = 32'h0;
      tick;
      chk("w1_access", {PSEL, PENABLE, rsp_valid}, 3'b110);
      chk("w1_hold", {PADDR, PWDATA, PSTRB}, {8'h10, 32'hDEADBEEF, 4'hF});
      tick;
      chk("w1_done", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b0011);
      chk("w1_rsp", {rsp_err, rsp_timeout, rsp_rdata}, 34'h0);
      tick;
      chk("w1_pulse1", rsp_valid, 0);

      // ---------------- read, 3 wait states ----------------
      cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h20;
      cmd_wdata = 32'hFFFFFFFF; cmd_strb = 4'hF;
      PRDATA = 32'h12345678; PREADY = 1;
      tick;
      chk("r_setup", {PSEL, PENABLE, PWRITE}, 3'b100);
      chk("r_pstrb0", PSTRB, 0);
      chk("r_pwdata0", PWDATA, 0);
      cmd_valid = 0;
      tick;
      PREADY = 0;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if ({PSEL, PENABLE, rsp_valid} !== 3'b110 || PADDR !== 8'h20 || PSTRB !== 4'h0)
            bad++;
         if (i == 3) PREADY = 1;
         tick;
      end
      chk("r_access4", bad, 0);
      chk("r_done", {PSEL, PENABLE, rsp_valid}, 3'b001);
      chk("r_rdata", rsp_rdata, 32'h12345678);
      chk("r_err", {rsp_err, rsp_timeout}, 2'b00);
      PRDATA = 32'h0;
      tick;
      chk("r_hold", {rsp_valid, rsp_rdata}, {1'b0, 32'h12345678});

      // ---------------- timeout at 16 wait states ----------------
      cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h40;
      PREADY = 0; PRDATA = 32'hCAFEF00D;
      tick;
      cmd_valid = 0;
      tick;
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         if ({PSEL, PENABLE, rsp_valid} !== 3'b110) bad++;
         tick;
      end
      chk("to_wait16", bad, 0);
      chk("to_abort", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b0011);
      chk("to_flags", {rsp_err, rsp_timeout}, 2'b11);
      chk("to_rdata", rsp_rdata, 0);

      // ---------------- PREADY on the limit cycle ----------------
      cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h44;
      PRDATA = 32'h5A5A5A5A;
      tick;
      cmd_valid = 0;
      tick;
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         if ({PSEL, PENABLE, rsp_valid} !== 3'b110) bad++;
         if (i == 15) PREADY = 1;
         tick;
      end
      chk("lim_wait", bad, 0);
      chk("lim_done", {PSEL, rsp_valid, rsp_err, rsp_timeout}, 4'b0100);
      chk("lim_rdata", rsp_rdata, 32'h5A5A5A5A);

      // ---------------- write with PSLVERR, zero strobes ----------------
      cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h30;
      cmd_wdata = 32'h11223344; cmd_strb = 4'h0;
      PREADY = 1; PSLVERR = 1;
      tick;
      cmd_valid = 0;
      chk("e_setup", {PSEL, PWRITE, PSTRB}, 6'b110000);
      chk("e_pwdata", PWDATA, 32'h11223344);
      tick;
      tick;
      chk("e_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b110);
      chk("e_rdata", rsp_rdata, 0);
      PSLVERR = 0;
      tick;

      // ---------------- timeout disabled instance ----------------
      z_cmd_valid = 1; z_cmd_write = 0; z_cmd_addr = 8'h80; z_PREADY = 0;
      tick;
      z_cmd_valid = 0;
      tick;
      bad = 0;
      for (int i = 0; i < 110; i++) begin
         if ({z_PSEL, z_PENABLE, z_rsp_valid} !== 3'b110) bad++;
         tick;
      end
      chk("to0_no_abort", bad, 0);
      z_PREADY = 1; z_PRDATA = 32'h0BADF00D;
      tick;
      chk("to0_done", {z_PSEL, z_rsp_valid, z_rsp_err, z_rsp_timeout}, 4'b0100);
      chk("to0_rdata", z_rsp_rdata, 32'h0BADF00D);
      z_PREADY = 0;

      // ---------------- back-to-back writes ----------------
      PREADY = 1;
      cmd_valid = 1; cmd_write = 1;
      for (int n = 0; n < 4; n++) begin
         chk("b2b_ready", cmd_ready, 1);
         if (n > 0) begin
            chk("b2b_gap", {PSEL, PENABLE}, 2'b00);
            chk("b2b_rsp", {rsp_valid, rsp_err}, {1'b1, ((n - 1) % 2 == 1) ? 1'b1 : 1'b0});
         end
         cmd_addr  = 8'h50 + 8'(n);
         cmd_wdata = 32'hA0000000 + 32'(n);
         cmd_strb  = 4'h1 << n;
         tick;
         chk("b2b_setup", {PSEL, PENABLE, rsp_valid, cmd_ready, PADDR, PSTRB},
             {4'b1000, 8'h50 + 8'(n), 4'h1 << n});
         PSLVERR = (n % 2 == 1);
         tick;
         chk("b2b_access", {PSEL, PENABLE}, 2'b11);
         tick;
         PSLVERR = 0;
      end
      cmd_valid = 0;
      chk("b2b_last", {rsp_valid, rsp_err}, 2'b11);
      tick;
      chk("b2b_end", {rsp_valid, PSEL, cmd_ready}, 3'b001);

      // ---------------- reset during ACCESS ----------------
      cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h60; PREADY = 0;
      tick;
      cmd_valid = 0;
      tick;
      chk("mr_in_access", {PSEL, PENABLE}, 2'b11);
      #3 PRESETn = 1'b0;
      #1;
      chk("mr_apb0", {PSEL, PENABLE, PWRITE, PADDR, PSTRB}, 0);
      chk("mr_rsp0", {cmd_ready, rsp_valid, rsp_err, rsp_timeout}, 0);
      chk("mr_rdata0", rsp_rdata, 0);
      PREADY = 1;
      tick;
      tick;
      PRESETn = 1'b1;
      tick;
      chk("mr_after", {cmd_ready, rsp_valid, PSEL}, 3'b100);
      cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h70;
      cmd_wdata = 32'h01020304; cmd_strb = 4'h3;
      tick;
      cmd_valid = 0;
      chk("mr_setup", {PSEL, PWRITE, PADDR, PSTRB}, {2'b11, 8'h70, 4'h3});
      tick;
      tick;
      chk("mr_done", {rsp_valid, rsp_err, rsp_timeout, PSEL}, 4'b1000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
